// File: rtl/fft8_pkg.sv
// fft8_pkg: shared constants, complex/frame types and flat-bus helpers for the 8-point FFT controller
package fft8_pkg;
  localparam int N = 8;
  localparam int DW = 16;
  localparam int FFT_LAT = 5;
  localparam int LOG2N = 3;
  localparam int FRAC_BITS = 12;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;
  typedef cplx_t [N-1:0] frame_t;
  typedef enum logic [1:0] {LOAD, WAIT, UNLOAD} state_t;
  // Flat bus: element k real at [(2k)*DW +: DW], imag at [(2k+1)*DW +: DW]
  function automatic logic [N*2*DW-1:0] pack_frame(frame_t f);
    logic [N*2*DW-1:0] b;
    b = '0;
    for (int k = 0; k < N; k++) begin
      b[2*k*DW +: DW] = f[k].re;
      b[(2*k+1)*DW +: DW] = f[k].im;
    end
    return b;
  endfunction
  function automatic frame_t unpack_frame(logic [N*2*DW-1:0] b);
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f[k].re = b[2*k*DW +: DW];
      f[k].im = b[(2*k+1)*DW +: DW];
    end
    return f;
  endfunction
  function automatic logic signed [DW-1:0] scale_bin(logic signed [DW-1:0] x);
    logic signed [DW:0] s;
    s = (DW+1)'(x) + (DW+1)'(4);
    s = s >>> LOG2N;
    return (s > (DW+1)'(2**(DW-1)-1)) ? {1'b0, {(DW-1){1'b1}}} : s[DW-1:0];
  endfunction
endpackage

// File: rtl/fft8_frame_ctrl_if.sv
// fft8_frame_ctrl_if: sample-in and bin-out valid/ready streams of the FFT frame controller
interface fft8_frame_ctrl_if;
  import fft8_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [DW-1:0] in_re, in_im, out_re, out_im;
  modport master (output in_valid, in_re, in_im, out_ready, input in_ready, out_valid, out_re, out_im, out_last);
  modport slave (input in_valid, in_re, in_im, out_ready, output in_ready, out_valid, out_re, out_im, out_last);
endinterface

// File: rtl/fft8_frame_buf.sv
// fft8_frame_buf: N-entry complex register file with single-entry write, whole-frame load and indexed read
module fft8_frame_buf import fft8_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [LOG2N-1:0] wa,
  input  cplx_t            wd,
  input  logic             ld,
  input  frame_t           ld_data,
  input  logic [LOG2N-1:0] ra,
  output cplx_t            rd,
  output frame_t           q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (ld) q <= ld_data;
    else if (we) q[wa] <= wd;
  end
  assign rd = q[ra];
endmodule

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: frames 8 streamed samples into the FFT core and streams its bins back out; FFT_CTRL_SCALE_EN scales bins by 1/8
module fft8_frame_ctrl import fft8_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  fft8_frame_ctrl_if.slave  s,
  output logic [N*2*DW-1:0] fft_x,
  input  logic [N*2*DW-1:0] fft_y,
  output logic              busy
);
  if (N != 8) begin : g_n_check
    $error("fft8_frame_ctrl supports N=8 only");
  end
  state_t state;
  logic [LOG2N-1:0] idx;
  logic [2:0] lat;
  logic in_xfer, out_xfer, cap;
  cplx_t in_c, rd, unused_in_rd;
  frame_t in_q, load_f, cap_f, unused_res_q;
  assign in_c = '{re: s.in_re, im: s.in_im};
  assign s.in_ready = state == LOAD && !reset;
  assign s.out_valid = state == UNLOAD;
  assign s.out_re = s.out_valid ? rd.re : '0;
  assign s.out_im = s.out_valid ? rd.im : '0;
  assign s.out_last = s.out_valid && idx == LOG2N'(N - 1);
  assign busy = state != LOAD;
  assign in_xfer = s.in_valid && s.in_ready;
  assign out_xfer = s.out_valid && s.out_ready;
  assign cap = state == WAIT && lat == 3'(FFT_LAT);
  // The last sample is merged in so fft_x updates on the same edge it arrives
  always_comb begin
    load_f = in_q;
    load_f[idx] = in_c;
  end
`ifdef FFT_CTRL_SCALE_EN
  frame_t y_f;
  always_comb begin
    y_f = unpack_frame(fft_y);
    for (int k = 0; k < N; k++) cap_f[k] = '{re: scale_bin(y_f[k].re), im: scale_bin(y_f[k].im)};
  end
`else
  assign cap_f = unpack_frame(fft_y);
`endif
  fft8_frame_buf u_in (
    .clk(clk), .reset(reset), .we(in_xfer), .wa(idx), .wd(in_c),
    .ld(1'b0), .ld_data('0), .ra(idx), .rd(unused_in_rd), .q(in_q)
  );
  fft8_frame_buf u_res (
    .clk(clk), .reset(reset), .we(1'b0), .wa('0), .wd('0),
    .ld(cap), .ld_data(cap_f), .ra(idx), .rd(rd), .q(unused_res_q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      idx <= '0;
      lat <= '0;
      fft_x <= '0;
    end else begin
      unique case (state)
        LOAD: if (in_xfer) begin
          idx <= idx + 1'b1;
          if (idx == LOG2N'(N - 1)) begin
            fft_x <= pack_frame(load_f);
            state <= WAIT;
          end
        end
        WAIT: begin
          lat <= cap ? '0 : lat + 1'b1;
          if (cap) state <= UNLOAD;
        end
        UNLOAD: if (out_xfer) begin
          idx <= idx + 1'b1;
          if (idx == LOG2N'(N - 1)) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: directed frames through the controller with a pipelined DFT stand-in for the core and a bin scoreboard
module tb_fft8_frame_ctrl;
  logic clk = 0;
  logic reset = 1;
  logic [255:0] fft_x, fft_y;
  logic busy;
  fft8_frame_ctrl_if bus();
  fft8_frame_ctrl dut (.clk(clk), .reset(reset), .s(bus), .fft_x(fft_x), .fft_y(fft_y), .busy(busy));
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_xfer = 0;
  int bin_i = 0;
  bit bp = 0;
  logic [31:0] exp_q[$];
  logic [255:0] pipe [5];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Reference DFT with twiddles rounded to Q1.14 and results rounded half-up
  function automatic logic [255:0] dft(input logic [255:0] x);
    int wr[8], wi[8], m;
    longint ar, ai;
    logic signed [15:0] xr, xi;
    logic [255:0] y;
    wr = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    wi = '{0, -11585, -16384, -11585, 0, 11585, 16384, 11585};
    y = '0;
    for (int k = 0; k < 8; k++) begin
      ar = 0;
      ai = 0;
      for (int n = 0; n < 8; n++) begin
        m = (n * k) % 8;
        xr = x[32*n +: 16];
        xi = x[32*n+16 +: 16];
        ar += longint'(xr) * wr[m] - longint'(xi) * wi[m];
        ai += longint'(xr) * wi[m] + longint'(xi) * wr[m];
      end
      ar = (ar + 8192) >>> 14;
      ai = (ai + 8192) >>> 14;
      y[32*k +: 16] = ar[15:0];
      y[32*k+16 +: 16] = ai[15:0];
    end
    return y;
  endfunction
  always @(posedge clk) begin
    pipe[0] <= dft(fft_x);
    for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
  end
  assign fft_y = pipe[4];
`ifdef FFT_CTRL_SCALE_EN
  function automatic logic [15:0] scl(input logic [15:0] v);
    int t;
    t = ($signed(v) + 4) >>> 3;
    if (t > 32767) t = 32767;
    return t[15:0];
  endfunction
`endif
  task automatic push_exp(input logic [255:0] y);
    logic [15:0] re, im;
    for (int k = 0; k < 8; k++) begin
      re = y[32*k +: 16];
      im = y[32*k+16 +: 16];
`ifdef FFT_CTRL_SCALE_EN
      re = scl(re);
      im = scl(im);
`endif
      exp_q.push_back({re, im});
    end
  endtask
  task automatic send(input logic [15:0] re, input logic [15:0] im, input int gap, input bit drop);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
    bus.in_valid = 1;
    bus.in_re = re;
    bus.in_im = im;
    @(posedge clk);
    #1;
    last_xfer = cyc;
    if (drop) bus.in_valid = 0;
    repeat (gap) @(posedge clk);
  endtask
  task automatic send_frame(input logic [255:0] f, input bit drop_last);
    for (int k = 0; k < 8; k++) send(f[32*k +: 16], f[32*k+16 +: 16], 0, k == 7 && drop_last);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp ? (cyc % 3 == 1) : 1'b1;
    end
  end
  // Each presented bin must match the scoreboard head, stalled or not
  always @(negedge clk) begin
    if (bus.out_valid) begin
      check("sb_not_empty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("in_ready_low", bus.in_ready, 0);
        check("bin", {bus.out_re, bus.out_im}, exp_q[0]);
        check("last", bus.out_last, bin_i == 7);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          bin_i = (bin_i + 1) % 8;
        end
      end
    end
  end
  initial begin
    logic [255:0] imp, imp_y, dc, dc_y, rmp, fa, fb;
    logic [15:0] t;
    int n;
    bus.in_valid = 0;
    bus.in_re = 0;
    bus.in_im = 0;
    imp = '0;
    imp[15:0] = 16'h1000;
    imp_y = '0;
    dc = '0;
    dc_y = '0;
    dc_y[15:0] = 16'h4000;
    rmp = '0;
    fa = '0;
    fb = '0;
    for (int k = 0; k < 8; k++) begin
      imp_y[32*k +: 16] = 16'h1000;
      dc[32*k +: 16] = 16'h0800;
      rmp[32*k +: 16] = 16'(k * 256);
      fa[32*k +: 16] = 16'(k * 291 - 768);
      fa[32*k+16 +: 16] = 16'(512 - k * 81);
      t = 16'($urandom_range(0, 4095)) - 16'd2048;
      fb[32*k +: 16] = t;
      t = 16'($urandom_range(0, 4095)) - 16'd2048;
      fb[32*k+16 +: 16] = t;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fft_x", fft_x, 0);
    check("rst_out_data", {bus.out_re, bus.out_im, bus.out_last}, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);
    push_exp(imp_y);
    send_frame(imp, 1);
    @(negedge clk);
    check("in_ready_drop", bus.in_ready, 0);
    check("busy_wait", busy, 1);
    check("fft_x_impulse", fft_x, imp);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_valid_latency", cyc - last_xfer, 6);
    drain();
    push_exp(dc_y);
    send_frame(dc, 1);
    drain();
    bp = 1;
    push_exp(dc_y);
    send_frame(dc, 1);
    drain();
    bp = 0;
    push_exp(dft(rmp));
    for (int k = 0; k < 8; k++) begin
      send(rmp[32*k +: 16], rmp[32*k+16 +: 16], 1, 1);
      if (k == 6) begin
        @(negedge clk);
        check("fft_x_hold", fft_x, dc);
      end
    end
    @(negedge clk);
    check("fft_x_ramp", fft_x, rmp);
    drain();
    push_exp(dft(fa));
    push_exp(dft(fb));
    send_frame(fa, 0);
    send_frame(fb, 1);
    drain();
    for (int k = 0; k < 5; k++) send(16'h0700, 16'h0100, 0, k == 4);
    reset = 1;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fft_x", fft_x, 0);
    push_exp(imp_y);
    send_frame(imp, 1);
    drain();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("idle_out_valid", bus.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
